mem_pwr_seq: RTL
================

// Module: mem_pwr_seq
// PURPOSE
//  Power sequencer for the memory-controller power domain. It drives the
//  iso_up/pwr_up/save/restore controls of that domain and owns its
//  sleep/wake flow: drain traffic, save retention state, isolate, power off,
//  then the reverse on wake. Sits between the system power manager
//  (sleep_req/wake_req) and the memory controller.
// PARAMETERS
//  SAVE_CYC     default 2   cycles save is held high (>=1, <2**CNT_W)
//  RESTORE_CYC  default 2   cycles restore is held high (>=1, <2**CNT_W)
//  PWR_TMO      default 12  max cycles in PWRON waiting for pwr_good (>=1, <2**CNT_W)
//  CNT_W        default 4   width of internal cycle counter
// PORTS
//  clk        in   1  clock
//  reset      in   1  asynchronous, active-high reset
//  sleep_req  in   1  level; request to power the domain down
//  wake_req   in   1  level; request to power the domain up
//  busy       in   1  controller has a pending rx/tx request or non-empty temp fifo
//  pwr_good   in   1  power switch reports domain supply stable
//  pwr_up     out  1  1 = domain power switch on
//  iso_up     out  1  1 = domain outputs clamped (isolation on)
//  save       out  1  retention save strobe (level, SAVE_CYC cycles)
//  restore    out  1  retention restore strobe (level, RESTORE_CYC cycles)
//  sleep_ack  out  1  1-cycle pulse on entry to OFF
//  wake_ack   out  1  1-cycle pulse on entry to RUN from UNISO
//  pwr_err    out  1  sticky: pwr_good timeout; cleared only by reset
//  state      out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  States (encoding): RUN=0 DRAIN=1 SAVE=2 ISO=3 OFF=4 PWRON=5 RESTORE=6 UNISO=7.
//  Outputs are flops loaded on the same edge as the state; no comb paths in->out.
//  Output table (pwr_up,iso_up,save,restore):
//    RUN/DRAIN 1,0,0,0 | SAVE 1,0,1,0 | ISO 1,1,0,0 | OFF 0,1,0,0
//    PWRON 1,1,0,0 | RESTORE 1,1,0,1 | UNISO 1,1,0,0
//  Reset: state=RUN, pwr_up=1, iso_up=0, save=0, restore=0, sleep_ack=0,
//    wake_ack=0, pwr_err=0, counter=0. Reset mid-sequence returns to RUN at
//    once (domain is assumed repowered by the system reset path).
//  Transitions (evaluated each posedge):
//    RUN:     sleep_req & !wake_req -> DRAIN; both high -> stay RUN (wake wins).
//    DRAIN:   wake_req -> RUN (abort, no wake_ack); else !busy -> SAVE; else hold.
//    SAVE:    counter counts 0..SAVE_CYC-1; at SAVE_CYC-1 -> ISO.
//             save is high exactly SAVE_CYC cycles. wake_req ignored.
//    ISO:     1 cycle -> OFF (isolation settles before power drops).
//    OFF:     sleep_ack pulses on the entry cycle; wake_req -> PWRON.
//             If wake_req is already high on entry, PWRON follows next cycle.
//    PWRON:   pwr_good -> RESTORE. Counter counts PWR_TMO cycles; if pwr_good
//             is still low at count PWR_TMO-1, set pwr_err and stay in PWRON
//             (counter saturates; pwr_good later still advances to RESTORE).
//    RESTORE: restore high exactly RESTORE_CYC cycles, then -> UNISO.
//    UNISO:   1 settle cycle with iso still up, then -> RUN; wake_ack pulses
//             on RUN entry. sleep_req ignored until RUN.
//  Counter: clears to 0 on every state change; CNT_W-bit, never wraps.
//  iso_up rises no later than pwr_up falls and falls only after restore ends.
//  save/restore are never high together; pwr_up=0 only in OFF.
//  state output holds the encoding of the current state register.
// TESTING
//  1 reset -> RUN; pwr_up=1 iso_up=0 save=0 restore=0 pwr_err=0 state=0.
//  2 sleep_req=1, busy=0 -> DRAIN,SAVE(2 cyc save=1),ISO,OFF; sleep_ack 1 cycle
//    on OFF entry; pwr_up=0 iso_up=1 in OFF.
//  3 from OFF, wake_req=1, pwr_good after 3 cycles -> PWRON 3 cyc, RESTORE
//    (restore=1 for 2 cyc), UNISO, RUN; wake_ack 1 pulse; iso_up=0 in RUN.
//  4 sleep_req=1 with busy=1 for 5 cycles, wake_req=1 on cycle 3 -> DRAIN
//    aborts to RUN; save never asserted; no sleep_ack or wake_ack.
//  5 PWRON with pwr_good=0 for 12 cycles -> pwr_err=1, state stays 5;
//    pwr_good=1 -> RESTORE; pwr_err stays 1 until reset.
//  6 reset asserted in RESTORE -> immediately state=0, pwr_up=1, iso_up=0,
//    restore=0; also sleep_req=wake_req=1 in RUN -> stays RUN.

Source files
------------

// File: rtl/mem_pwr_seq.sv
// -----------------------------------------------------------------------------
// mem_pwr_seq
//   Power sequencer for the memory-controller power domain. Owns the
//   sleep/wake flow of that domain:
//     sleep: RUN -> DRAIN -> SAVE -> ISO -> OFF
//     wake : OFF -> PWRON -> RESTORE -> UNISO -> RUN
//   DRAIN can abort back to RUN on wake_req. Every output is a flop loaded on
//   the same edge as the state register, so there is no combinational path
//   from any input to any output.
//
// Parameters
//   SAVE_CYC     cycles save is held high       (>=1, <2**CNT_W)
//   RESTORE_CYC  cycles restore is held high    (>=1, <2**CNT_W)
//   PWR_TMO      cycles in PWRON before pwr_err (>=1, <2**CNT_W)
//   CNT_W        width of the internal cycle counter
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset (returns to RUN, domain on)
//   sleep_req  level request to power the domain down
//   wake_req   level request to power the domain up (wins over sleep_req)
//   busy       controller still has traffic or a non-empty temp fifo
//   pwr_good   power switch reports the domain supply is stable
//   pwr_up     domain power switch on
//   iso_up     domain outputs clamped
//   save       retention save strobe, SAVE_CYC cycles
//   restore    retention restore strobe, RESTORE_CYC cycles
//   sleep_ack  1-cycle pulse on entry to OFF
//   wake_ack   1-cycle pulse on entry to RUN from UNISO
//   pwr_err    sticky pwr_good timeout flag, cleared only by reset
//   state      current state encoding (debug)
// -----------------------------------------------------------------------------
module mem_pwr_seq #(
  parameter int SAVE_CYC    = 2,
  parameter int RESTORE_CYC = 2,
  parameter int PWR_TMO     = 12,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       busy,
  input  logic       pwr_good,
  output logic       pwr_up,
  output logic       iso_up,
  output logic       save,
  output logic       restore,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic       pwr_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_DRAIN   = 3'd1,
    S_SAVE    = 3'd2,
    S_ISO     = 3'd3,
    S_OFF     = 3'd4,
    S_PWRON   = 3'd5,
    S_RESTORE = 3'd6,
    S_UNISO   = 3'd7
  } st_e;

  // Domain control word, one bit per power-control output.
  typedef struct packed {
    logic pwr_up;
    logic iso_up;
    logic save;
    logic restore;
  } dom_ctl_t;

  // Terminal counts of the timed states.
  localparam logic [CNT_W-1:0] SAVE_LAST = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(RESTORE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(PWR_TMO - 1);

  localparam dom_ctl_t CTL_RESET = '{pwr_up: 1'b1, iso_up: 1'b0,
                                     save: 1'b0, restore: 1'b0};

  st_e              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dom_ctl_t         ctl_d;
  logic             sack_d, wack_d, err_d;
  logic             tmo;

  // Control word a state drives. Isolation is raised in ISO before power
  // drops in OFF and is held through RESTORE and UNISO, so the clamp is
  // always up while the domain outputs may be undefined.
  function automatic dom_ctl_t ctl_of(input st_e s);
    dom_ctl_t c;
    c = CTL_RESET;
    case (s)
      S_RUN, S_DRAIN: c = '{pwr_up: 1'b1, iso_up: 1'b0, save: 1'b0, restore: 1'b0};
      S_SAVE:         c = '{pwr_up: 1'b1, iso_up: 1'b0, save: 1'b1, restore: 1'b0};
      S_ISO:          c = '{pwr_up: 1'b1, iso_up: 1'b1, save: 1'b0, restore: 1'b0};
      S_OFF:          c = '{pwr_up: 1'b0, iso_up: 1'b1, save: 1'b0, restore: 1'b0};
      S_PWRON:        c = '{pwr_up: 1'b1, iso_up: 1'b1, save: 1'b0, restore: 1'b0};
      S_RESTORE:      c = '{pwr_up: 1'b1, iso_up: 1'b1, save: 1'b0, restore: 1'b1};
      S_UNISO:        c = '{pwr_up: 1'b1, iso_up: 1'b1, save: 1'b0, restore: 1'b0};
      default:        c = CTL_RESET;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    st_d = st_q;
    tmo  = 1'b0;
    case (st_q)
      // wake_req wins when both requests are high.
      S_RUN:     if (sleep_req && !wake_req) st_d = S_DRAIN;
      // Abort back to RUN before any retention state has been touched.
      S_DRAIN: begin
        if (wake_req)   st_d = S_RUN;
        else if (!busy) st_d = S_SAVE;
      end
      // Committed to sleep from here on: wake_req is not looked at until OFF.
      S_SAVE:    if (cnt_q == SAVE_LAST) st_d = S_ISO;
      S_ISO:     st_d = S_OFF;
      S_OFF:     if (wake_req) st_d = S_PWRON;
      // A late pwr_good still completes the wake; the timeout only flags it.
      S_PWRON: begin
        if (pwr_good)               st_d = S_RESTORE;
        else if (cnt_q == TMO_LAST) tmo  = 1'b1;
      end
      S_RESTORE: if (cnt_q == REST_LAST) st_d = S_UNISO;
      S_UNISO:   st_d = S_RUN;
      default:   st_d = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Cycle counter: cleared on every state change, only advances in the timed
  // states. In PWRON it stops at the timeout count so it can never wrap while
  // waiting indefinitely for pwr_good.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = '0;
    if (st_d == st_q) begin
      case (st_q)
        S_SAVE, S_RESTORE: cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        S_PWRON:           cnt_d = (cnt_q == TMO_LAST) ? cnt_q : cnt_q + 1'b1;
        default:           cnt_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next outputs, derived from the state being entered so they line up with
  // the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctl_d  = ctl_of(st_d);
    sack_d = (st_d == S_OFF) && (st_q != S_OFF);
    wack_d = (st_d == S_RUN) && (st_q == S_UNISO);
    err_d  = pwr_err | tmo;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q                            <= S_RUN;
      cnt_q                           <= '0;
      {pwr_up, iso_up, save, restore} <= CTL_RESET;
      sleep_ack                       <= 1'b0;
      wake_ack                        <= 1'b0;
      pwr_err                         <= 1'b0;
    end else begin
      st_q                            <= st_d;
      cnt_q                           <= cnt_d;
      {pwr_up, iso_up, save, restore} <= ctl_d;
      sleep_ack                       <= sack_d;
      wake_ack                        <= wack_d;
      pwr_err                         <= err_d;
    end
  end

  assign state = st_q;

endmodule
